hazard_stall_ctrl: RTL and testbench

- Pipeline hazard controller that sequences the IF/ID front end of the 5-stage MIPS core.
- Decodes the instruction held in ID and keeps a 3-entry scoreboard of in-flight destination registers (EX, MEM, WB).
- Detects read-after-write hazards and branch/jump redirects. Drives PC-write enable, IF/ID write enable, IF/ID flush and an ID/EX bubble, so the instruction ROM no longer needs hand-inserted nops.

---
 rtl/hazard_stall_ctrl.sv | 139 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: RAW-hazard stall and branch/jump flush sequencing for the IF/ID front end.
// Optional macro FORWARDING_EN: EX/MEM forwarding exists, so only load-use and branch-operand hazards stall.
module hazard_stall_ctrl #(
    parameter int WB_SPLIT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_id,
    input  logic             id_valid,
    input  logic             branch_taken,
    input  logic             jump,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef struct packed {
        logic       vld;
        logic [4:0] dst;
        logic       load;
    } sb_ent_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    sb_ent_t          ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic [5:0] opcode;
    logic [4:0] rs, rt, rd;
    logic       rd_rs, rd_rt, is_branch;
    sb_ent_t    id_ent;
    logic       hz_ex, hz_mem, hz_wb, hazard, stall, flush;
    logic       unused_bits;

    function automatic logic src_hit(input logic en, input logic [4:0] src, input sb_ent_t e);
        return en && (src != 5'd0) && e.vld && (e.dst == src);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + {{(CNT_W-1){1'b0}}, 1'b1} : v;
    endfunction

    always_comb begin
        opcode    = instr_id[31:26];
        rs        = instr_id[25:21];
        rt        = instr_id[20:16];
        rd        = instr_id[15:11];
        rd_rs     = 1'b0;
        rd_rt     = 1'b0;
        is_branch = 1'b0;
        id_ent    = '0;
        if (id_valid && (instr_id != 32'd0)) begin
            case (opcode)
                OP_RTYPE: begin
                    rd_rs      = 1'b1;
                    rd_rt      = 1'b1;
                    id_ent.vld = 1'b1;
                    id_ent.dst = rd;
                end
                OP_ADDI: begin
                    rd_rs      = 1'b1;
                    id_ent.vld = 1'b1;
                    id_ent.dst = rt;
                end
                OP_LW: begin
                    rd_rs       = 1'b1;
                    id_ent.vld  = 1'b1;
                    id_ent.dst  = rt;
                    id_ent.load = 1'b1;
                end
                OP_SW: begin
                    rd_rs = 1'b1;
                    rd_rt = 1'b1;
                end
                OP_BEQ, OP_BNE: begin
                    rd_rs     = 1'b1;
                    rd_rt     = 1'b1;
                    is_branch = 1'b1;
                end
                default: ;
            endcase
        end
        // a write to $0 is discarded, so it must never look like a producer
        if (id_ent.dst == 5'd0) id_ent = '0;
    end

    always_comb begin
        hz_ex  = src_hit(rd_rs, rs, ex_q)  || src_hit(rd_rt, rt, ex_q);
        hz_mem = src_hit(rd_rs, rs, mem_q) || src_hit(rd_rt, rt, mem_q);
        hz_wb  = src_hit(rd_rs, rs, wb_q)  || src_hit(rd_rt, rt, wb_q);
`ifdef FORWARDING_EN
        // branches compare in ID, so they cannot take a forwarded EX result
        hazard = is_branch ? (hz_ex || (hz_mem && mem_q.load)) : (hz_ex && ex_q.load);
        unused_bits = ^{instr_id[10:0], hz_wb, wb_q};
`else
        hazard = hz_ex || hz_mem || ((WB_SPLIT == 0) && hz_wb);
        unused_bits = ^{instr_id[10:0], wb_q.load, is_branch};
`endif
        stall        = hazard && !reset;
        flush        = (branch_taken || jump) && !stall && !reset;
        pc_write     = !stall;
        if_id_write  = !stall;
        id_ex_bubble = stall;
        if_id_flush  = flush;

        ex_d        = stall ? '0 : id_ent;
        mem_d       = ex_q;
        wb_d        = mem_q;
        stall_cnt_d = sat_inc(stall_cnt_q, stall);
        flush_cnt_d = sat_inc(flush_cnt_q, flush);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: one WB_SPLIT=1/CNT_W=16 instance and one WB_SPLIT=0/CNT_W=4 instance.
module tb_hazard_stall_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [31:0] instr_id = 32'd0;
    logic        id_valid = 1'b0;
    logic        branch_taken = 1'b0;
    logic        jump = 1'b0;

    logic        pc_write_a, if_id_write_a, if_id_flush_a, id_ex_bubble_a;
    logic [15:0] stall_cnt_a, flush_cnt_a;
    logic        pc_write_b, if_id_write_b, if_id_flush_b, id_ex_bubble_b;
    logic [3:0]  stall_cnt_b, flush_cnt_b;

    int n_cmp = 0;
    int n_mis = 0;

    localparam logic [31:0] LW_S1   = 32'h8D31_0000; // lw   $s1,0($t1)
    localparam logic [31:0] ADD_S1  = 32'h0251_8820; // add  reads $s2,$s1
    localparam logic [31:0] ADDI_T1 = 32'h2129_FFFC; // addi $t1,$t1,-4
    localparam logic [31:0] BNE_T1  = 32'h1609_FFFC; // bne  $t1,$s0
    localparam logic [31:0] ADDI_T2 = 32'h214A_0001; // addi $t2,$t2,1
    localparam logic [31:0] ADD_T1  = 32'h0129_5820; // add  $t3,$t1,$t1
    localparam logic [31:0] J_INS   = 32'h0800_0010; // j
    localparam logic [31:0] LW_R1   = 32'h8C21_0000; // lw   $1,0($1)

`ifdef FORWARDING_EN
    localparam int LU_STALLS = 1;
    localparam int BR_STALLS = 1;
    localparam int ALU_S1    = 0;
    localparam int ALU_S0    = 0;
`else
    localparam int LU_STALLS = 2;
    localparam int BR_STALLS = 2;
    localparam int ALU_S1    = 1;
    localparam int ALU_S0    = 2;
`endif

    hazard_stall_ctrl #(.WB_SPLIT(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .instr_id(instr_id), .id_valid(id_valid),
        .branch_taken(branch_taken), .jump(jump),
        .pc_write(pc_write_a), .if_id_write(if_id_write_a), .if_id_flush(if_id_flush_a),
        .id_ex_bubble(id_ex_bubble_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
    );

    hazard_stall_ctrl #(.WB_SPLIT(0), .CNT_W(4)) dut_w0 (
        .clk(clk), .reset(reset), .instr_id(instr_id), .id_valid(id_valid),
        .branch_taken(branch_taken), .jump(jump),
        .pc_write(pc_write_b), .if_id_write(if_id_write_b), .if_id_flush(if_id_flush_b),
        .id_ex_bubble(id_ex_bubble_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
    );

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
    wire [3:0] ctrl_a = {pc_write_a, if_id_write_a, if_id_flush_a, id_ex_bubble_a};
    wire [3:0] ctrl_b = {pc_write_b, if_id_write_b, if_id_flush_b, id_ex_bubble_b};

    localparam logic [3:0] RUN   = 4'b1100;
    localparam logic [3:0] STALL = 4'b0001;
    localparam logic [3:0] FLUSH = 4'b1110;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [31:0] ins, input logic vld, input logic bt,
                       input logic jmp, input logic rst);
        @(negedge clk);
        instr_id     = ins;
        id_valid     = vld;
        branch_taken = bt;
        jump         = jmp;
        reset        = rst;
        #1;
    endtask

    task automatic do_reset();
        cyc(32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        // reset held two cycles, then idle
        cyc(32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_eq("rst_ctrl_a", ctrl_a, RUN);
        cyc(32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_eq("rst_ctrl_b", ctrl_b, RUN);
        for (int i = 0; i < 5; i++) begin
            cyc(32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            chk_eq("idle_ctrl_a", ctrl_a, RUN);
        end
        chk_eq("idle_stall_cnt", stall_cnt_a, 0);
        chk_eq("idle_flush_cnt", flush_cnt_a, 0);
        chk_eq("idle_stall_cnt_b", stall_cnt_b, 0);

        // load-use
        do_reset();
        cyc(LW_S1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_eq("lu_issue", ctrl_a, RUN);
        for (int i = 0; i < LU_STALLS; i++) begin
            cyc(ADD_S1, 1'b1, 1'b0, 1'b0, 1'b0);
            chk_eq("lu_stall", ctrl_a, STALL);
        end
        cyc(ADD_S1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_eq("lu_release", ctrl_a, RUN);
        chk_eq("lu_stall_cnt", stall_cnt_a, LU_STALLS);

        // reset during the first stall cycle
        do_reset();
        cyc(LW_S1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(ADD_S1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_eq("rs_stall", ctrl_a, STALL);
        cyc(ADD_S1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_eq("rs_during", ctrl_a, RUN);
        cyc(ADD_S1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_eq("rs_after", ctrl_a, RUN);
        chk_eq("rs_stall_cnt", stall_cnt_a, 0);

        // branch operand hazard; redirect ignored while stalled
        do_reset();
        cyc(ADDI_T1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < BR_STALLS; i++) begin
            cyc(BNE_T1, 1'b1, 1'b1, 1'b0, 1'b0);
            chk_eq("br_stall", ctrl_a, STALL);
        end
        cyc(BNE_T1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_eq("br_flush", ctrl_a, FLUSH);
        cyc(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_eq("br_after", ctrl_a, RUN);
        chk_eq("br_flush_cnt", flush_cnt_a, 1);
        chk_eq("br_stall_cnt", stall_cnt_a, BR_STALLS);

        // producer two ahead: WB counts only without the split write
        do_reset();
        cyc(ADDI_T1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(ADDI_T2, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(ADD_T1, 1'b1, 1'b0, 1'b0, 1'b0);
            chk_eq("wb1_ctrl", ctrl_a, (i < ALU_S1) ? STALL : RUN);
            chk_eq("wb0_ctrl", ctrl_b, (i < ALU_S0) ? STALL : RUN);
        end
        chk_eq("wb0_stall_cnt", stall_cnt_b, ALU_S0);
        chk_eq("wb1_stall_cnt", stall_cnt_a, ALU_S1);

        // jump with no hazard
        do_reset();
        cyc(J_INS, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_eq("jmp_ctrl_a", ctrl_a, FLUSH);
        chk_eq("jmp_ctrl_b", ctrl_b, FLUSH);
        cyc(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_eq("jmp_flush_cnt", flush_cnt_a, 1);

        // stall counter saturation on the 4-bit instance
        do_reset();
        for (int i = 0; i < 40; i++) cyc(LW_R1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_eq("sat_stall_cnt", stall_cnt_b, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
